// File: rtl/if_id_decode_if.sv
// if_id_decode_if: bundle of fetch-side inputs, pipeline control and
// decode-side outputs of the IF/ID pipeline register.
//   master: fetch / hazard-control side (drives f_*, stall, flush, ex_*)
//   slave : the IF/ID register itself (drives d_*, hazard_stall)
interface if_id_decode_if #(
  parameter int unsigned XLEN = 32
);
  // fetch side and pipeline control
  logic            f_valid;
  logic [XLEN-1:0] f_pc;
  logic [XLEN-1:0] f_inst;
  logic            stall;
  logic            flush;
  logic            ex_mem_read;
  logic [4:0]      ex_rd;
  // decode side
  logic            d_valid;
  logic [XLEN-1:0] d_pc;
  logic [XLEN-1:0] d_inst;
  logic [6:0]      d_opcode;
  logic [4:0]      d_rd;
  logic [2:0]      d_funct3;
  logic [4:0]      d_rs1;
  logic [4:0]      d_rs2;
  logic [6:0]      d_funct7;
  logic [24:0]     d_imm;
  logic [2:0]      d_imm_type;
  logic            d_illegal;
  logic            hazard_stall;

  modport master (
    output f_valid, f_pc, f_inst, stall, flush, ex_mem_read, ex_rd,
    input  d_valid, d_pc, d_inst, d_opcode, d_rd, d_funct3, d_rs1, d_rs2,
           d_funct7, d_imm, d_imm_type, d_illegal, hazard_stall
  );

  modport slave (
    input  f_valid, f_pc, f_inst, stall, flush, ex_mem_read, ex_rd,
    output d_valid, d_pc, d_inst, d_opcode, d_rd, d_funct3, d_rs1, d_rs2,
           d_funct7, d_imm, d_imm_type, d_illegal, hazard_stall
  );
endinterface

// File: rtl/if_id_decode.sv
// if_id_decode: IF/ID pipeline register with instruction field decode and
// load-use hazard detection for the RV32I core.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - if_id_decode_if.slave: fetch inputs (f_valid/f_pc/f_inst), stall,
//          flush, EX-stage load info (ex_mem_read/ex_rd); outputs the latched
//          slot (d_valid/d_pc/d_inst), decoded fields, immediate selector,
//          illegal flag and hazard_stall.
module if_id_decode #(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   NOP_INST = 32'h0000_0013
) (
  input  logic           clk,
  input  logic           rst,
  if_id_decode_if.slave  bus
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;

  logic [2:0]      imm_type;
  logic            legal;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            hazard;

  // Format decode of the latched opcode.
  always_comb begin
    imm_type = 3'b111;
    legal    = 1'b1;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (inst_q[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        imm_type = 3'b000;
        uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        imm_type = 3'b001;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        imm_type = 3'b101;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: imm_type = 3'b010;
      OP_JAL:           imm_type = 3'b110;
      OP_REG: begin
        imm_type = 3'b111;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // A load in EX writing a register this instruction reads must wait one cycle.
  // x0 never carries a dependency.
  assign hazard = valid_q & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                  ((uses_rs1 & (bus.ex_rd == inst_q[19:15])) |
                   (uses_rs2 & (bus.ex_rd == inst_q[24:20])));

  // Next-state: flush beats any stall, stall/hazard holds, otherwise load.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      pc_d    = bus.f_pc;
      inst_d  = NOP_INST;
    end else if (!(bus.stall || hazard)) begin
      valid_d = bus.f_valid;
      pc_d    = bus.f_pc;
      inst_d  = bus.f_valid ? bus.f_inst : NOP_INST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign bus.d_valid      = valid_q;
  assign bus.d_pc         = pc_q;
  assign bus.d_inst       = inst_q;
  assign bus.d_opcode     = inst_q[6:0];
  assign bus.d_rd         = inst_q[11:7];
  assign bus.d_funct3     = inst_q[14:12];
  assign bus.d_rs1        = inst_q[19:15];
  assign bus.d_rs2        = inst_q[24:20];
  assign bus.d_funct7     = inst_q[31:25];
  assign bus.d_imm        = inst_q[31:7];
  assign bus.d_imm_type   = imm_type;
  assign bus.d_illegal    = valid_q & ~legal;
  assign bus.hazard_stall = hazard;

endmodule

// File: tb/tb_if_id_decode.sv
// tb_if_id_decode: directed + randomized bench for if_id_decode. A reference
// model of the slot (valid/pc/inst) is advanced on every rising edge and all
// decode outputs are checked against it on every falling edge; directed steps
// add literal expectations.
module tb_if_id_decode;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  if_id_decode_if bus ();

  if_id_decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  bit          model_ok = 1'b0;

  // Instruction format letter from the RV32I opcode map.
  function automatic byte fmt_of(input logic [6:0] op);
    case (op)
      7'h13, 7'h03, 7'h67: return "I";
      7'h23:               return "S";
      7'h63:               return "B";
      7'h37, 7'h17:        return "U";
      7'h6F:               return "J";
      7'h33:               return "R";
      default:             return "X";
    endcase
  endfunction

  function automatic logic [2:0] type_of(input byte f);
    case (f)
      "I": return 3'd0;
      "S": return 3'd1;
      "B": return 3'd5;
      "U": return 3'd2;
      "J": return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic exp_hazard(input logic v, input logic [31:0] inst,
                                      input logic mr, input logic [4:0] rd);
    byte f;
    logic r1, r2;
    f  = fmt_of(inst[6:0]);
    r1 = (f == "R" || f == "I" || f == "S" || f == "B");
    r2 = (f == "R" || f == "S" || f == "B");
    return v && mr && rd != 0 &&
           ((r1 && rd == inst[19:15]) || (r2 && rd == inst[24:20]));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge, full compare on each falling edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_valid  = 1'b0;
        m_pc     = 32'd0;
        m_inst   = NOP;
        model_ok = 1'b1;
      end else if (model_ok) begin
        if (bus.flush) begin
          m_valid = 1'b0;
          m_inst  = NOP;
          m_pc    = bus.f_pc;
        end else if (!(bus.stall || exp_hazard(m_valid, m_inst, bus.ex_mem_read, bus.ex_rd))) begin
          m_valid = bus.f_valid;
          m_pc    = bus.f_pc;
          m_inst  = bus.f_valid ? bus.f_inst : NOP;
        end
      end
      @(negedge clk);
      if (model_ok) begin
        check("d_valid", bus.d_valid, m_valid);
        check("d_pc", bus.d_pc, m_pc);
        check("d_inst", bus.d_inst, m_inst);
        check("fields", {bus.d_funct7, bus.d_rs2, bus.d_rs1, bus.d_funct3, bus.d_rd, bus.d_opcode},
              m_inst);
        check("d_imm", bus.d_imm, m_inst >> 7);
        check("d_imm_type", bus.d_imm_type, type_of(fmt_of(m_inst[6:0])));
        check("d_illegal", bus.d_illegal, m_valid && fmt_of(m_inst[6:0]) == "X");
        check("hazard_stall", bus.hazard_stall,
              exp_hazard(m_valid, m_inst, bus.ex_mem_read, bus.ex_rd));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic r, input logic fv, input logic [31:0] pc,
                        input logic [31:0] inst, input logic st, input logic fl,
                        input logic mr, input logic [4:0] erd);
    rst             = r;
    bus.f_valid     = fv;
    bus.f_pc        = pc;
    bus.f_inst      = inst;
    bus.stall       = st;
    bus.flush       = fl;
    bus.ex_mem_read = mr;
    bus.ex_rd       = erd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  op;
    case ($urandom_range(0, 10))
      0: op = 7'h13;  1: op = 7'h03;  2: op = 7'h67;  3: op = 7'h23;
      4: op = 7'h63;  5: op = 7'h37;  6: op = 7'h17;  7: op = 7'h6F;
      8: op = 7'h33;  9: op = 7'h33;  default: op = 7'($urandom);
    endcase
    w        = $urandom;
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    w[6:0]   = op;
    return w;
  endfunction

  logic [6:0]  walk_op  [6];
  logic [2:0]  walk_typ [6];

  initial begin
    walk_op  = '{7'b0100011, 7'b1100011, 7'b0110111, 7'b1101111, 7'b0110011, 7'b1111111};
    walk_typ = '{3'b001, 3'b101, 3'b010, 3'b110, 3'b111, 3'b111};

    // 1: reset for two cycles
    set_in(1, 0, 32'h0, 32'h0, 0, 0, 0, 5'd0);
    tick();
    tick();
    check("rst_valid", bus.d_valid, 1'b0);
    check("rst_inst", bus.d_inst, 32'h0000_0013);
    check("rst_imm_type", bus.d_imm_type, 3'b000);
    check("rst_hazard", bus.hazard_stall, 1'b0);

    // 2: addi x5,x5,10 at pc 0x40
    set_in(0, 1, 32'h40, 32'h00A2_8293, 0, 0, 0, 5'd0);
    tick();
    check("addi_imm", bus.d_imm, 25'h001_4505);
    check("addi_imm_type", bus.d_imm_type, 3'b000);
    check("addi_rs1", bus.d_rs1, 5'd5);
    check("addi_rd", bus.d_rd, 5'd5);
    check("addi_pc", bus.d_pc, 32'h40);

    // 3: opcode walk
    for (int i = 0; i < 6; i++) begin
      set_in(0, 1, 32'h100 + 32'(i * 4), {25'($urandom), walk_op[i]}, 0, 0, 0, 5'd0);
      tick();
      check("walk_imm_type", bus.d_imm_type, walk_typ[i]);
      check("walk_illegal", bus.d_illegal, (i == 5));
    end

    // 4: load-use hazard on add x6,x5,x7
    set_in(0, 1, 32'h200, 32'h0072_8333, 0, 0, 0, 5'd0);
    tick();
    set_in(0, 1, 32'h204, 32'h0000_0293, 0, 0, 1, 5'd5);
    #1;
    check("hz_add_rd5", bus.hazard_stall, 1'b1);
    tick();
    check("hz_hold_inst", bus.d_inst, 32'h0072_8333);
    check("hz_hold_pc", bus.d_pc, 32'h200);
    bus.ex_rd = 5'd0;
    #1;
    check("hz_rd0", bus.hazard_stall, 1'b0);
    tick();
    set_in(0, 1, 32'h300, 32'h0002_82B7, 0, 0, 0, 5'd0);
    tick();
    set_in(0, 1, 32'h304, 32'h0000_0013, 0, 0, 1, 5'd5);
    #1;
    check("hz_lui", bus.hazard_stall, 1'b0);

    // 5: stall+flush together, then stall alone for three cycles
    tick();
    set_in(0, 1, 32'h80, 32'h0072_8333, 1, 1, 0, 5'd0);
    tick();
    check("sf_valid", bus.d_valid, 1'b0);
    check("sf_inst", bus.d_inst, 32'h0000_0013);
    check("sf_pc", bus.d_pc, 32'h80);
    set_in(0, 1, 32'h44, 32'h00A2_8293, 0, 0, 0, 5'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 32'h500 + 32'(i), $urandom, 1, 0, 0, 5'd0);
      tick();
      check("stall_inst", bus.d_inst, 32'h00A2_8293);
      check("stall_pc", bus.d_pc, 32'h44);
      check("stall_valid", bus.d_valid, 1'b1);
    end

    // 6: reset while stalled with a live instruction
    set_in(1, 1, 32'h600, 32'h0072_8333, 1, 0, 0, 5'd0);
    tick();
    check("rststall_valid", bus.d_valid, 1'b0);
    check("rststall_pc", bus.d_pc, 32'h0);
    check("rststall_inst", bus.d_inst, 32'h0000_0013);

    // randomized traffic checked by the model
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), $urandom,
             rand_inst(), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)));
      tick();
    end

    set_in(0, 0, 32'h0, 32'h0, 0, 0, 0, 5'd0);
    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
